gate_resp_checker: RTL and testbench
====================================

# gate_resp_checker

Sequential response checker for the two-input gate cells (cmosand and siblings). It accepts a stimulus vector through a valid/ready handshake and drives it onto the gate inputs from registers. After a programmable settle interval it samples the gate output and compares it against a parameterised truth table. It also keeps saturating vector and error counts. It sits beside each gate cell in the self-checking benches and FPGA bring-up builds, and replaces hand-inspected waveforms.

## Interface
Parameters:
- TRUTH, 4'b1000: expected output indexed by {a,b}; bit 3 = a1b1, bit 0 = a0b0. The default is AND.
- SETTLE, 2: number of clock edges from vector acceptance to output sample. Legal range is 1..15.
- CNT_W, 8: width of the counters.

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- vec_valid, in, 1: stimulus vector present.
- vec_a, in, 1: stimulus bit a.
- vec_b, in, 1: stimulus bit b.
- vec_ready, out, 1: checker can accept a vector.
- dut_a, out, 1: registered a, driven to the gate under test.
- dut_b, out, 1: registered b, driven to the gate under test.
- dut_f, in, 1: gate output, for example f53.
- chk_valid, out, 1: one-cycle pulse; result fields are valid.
- chk_pass, out, 1: sampled dut_f equals exp_f.
- exp_f, out, 1: expected value for the vector just checked.
- vec_cnt, out, CNT_W: number of vectors checked, saturating.
- err_cnt, out, CNT_W: number of mismatches, saturating.
- err_sticky, out, 1: set on the first mismatch; cleared only by rst.

## Operation
The FSM has two states, IDLE and WAIT.

IDLE:
- vec_ready = 1.
- On an edge with vec_valid = 1: latch vec_a into dut_a and vec_b into dut_b, load timer = SETTLE-1, and go to WAIT.

WAIT:
- vec_ready = 0.
- vec_valid is ignored. Vectors offered while not ready are not accepted, and the source must hold them.
- When timer != 0: decrement timer on each edge.
- When timer == 0: on the next edge, do all of the following, then return to IDLE:
  - sample dut_f;
  - set exp_f = TRUTH[{dut_a,dut_b}] and chk_pass = (dut_f == exp_f);
  - pulse chk_valid;
  - increment vec_cnt;
  - on mismatch, increment err_cnt and set err_sticky.

Other rules:
- dut_a and dut_b hold their values until the next accepted vector. They do not return to 0 in IDLE.
- chk_pass and exp_f hold their last values after the chk_valid pulse ends.
- Counters saturate at 2^CNT_W-1 and never wrap.
- err_sticky stays set even if err_cnt is saturated.
- dut_f is compared as a plain bit; no X/Z handling in RTL. The bench flags X on dut_f separately.

Reset:
- When rst = 1 on an edge: state becomes IDLE and all outputs are cleared. This overrides any in-flight vector; a partly settled vector is dropped and not counted.
- Reset values: vec_ready = 1 (combinational from IDLE), dut_a = 0, dut_b = 0, chk_valid = 0, chk_pass = 0, exp_f = 0, vec_cnt = 0, err_cnt = 0, err_sticky = 0.

## Timing
- Vector accepted at edge E0. dut_a and dut_b are valid after E0.
- dut_f is sampled at edge E0+SETTLE.
- chk_valid is high for exactly the cycle following E0+SETTLE.
- vec_ready returns high in that same cycle. The earliest next acceptance is edge E0+SETTLE+1. Throughput is therefore one vector per SETTLE+1 cycles.
- SETTLE = 1: accept at E0, sample at E0+1, no WAIT count-down beyond one cycle.
- vec_valid asserted in the same cycle as the chk_valid pulse is accepted on the following edge. It does not disturb the reported result.
- rst takes priority over acceptance and over sampling on the same edge.

## Test plan
- **Default AND, SETTLE = 2, DUT = cmosand.** Apply vectors 00, 01, 10, 11 back-to-back with vec_valid held high.
  - Required: four chk_valid pulses, 3 cycles apart.
  - exp_f = 0, 0, 0, 1; chk_pass = 1 for all.
  - vec_cnt = 4, err_cnt = 0, err_sticky = 0.
- **Faulty DUT, dut_f tied to 1.** Apply the same four vectors.
  - Required: chk_pass = 0, 0, 0, 1.
  - err_cnt = 3, err_sticky = 1, vec_cnt = 4.
- **Handshake.** Pulse vec_valid with vector 11, then change vec_a/vec_b to 00 during WAIT while vec_valid = 1.
  - Required: dut_a = 1 and dut_b = 1 hold until chk_valid.
  - The 00 vector is accepted on the edge after the pulse and is checked as exp_f = 0.
- **Reset mid-operation.** Accept vector 11 and assert rst one edge later.
  - Required: no chk_valid pulse.
  - vec_cnt = 0, dut_a = 0, dut_b = 0, vec_ready = 1 the cycle after reset.
- **Saturation, CNT_W = 2, dut_f = 1.** Apply vector 00 five times.
  - Required: err_cnt and vec_cnt stick at 3; err_sticky = 1.
- **SETTLE = 1 with TRUTH = 4'b0111 (NAND).** Apply vector 11.
  - Required: chk_valid 1 cycle after the edge following acceptance; exp_f = 0.

Source files
------------

// File: rtl/gate_resp_checker.sv
// gate_resp_checker: drives a registered stimulus vector onto a two-input gate,
// waits a programmable settle interval, samples the gate output and compares it
// against a truth table. Keeps saturating vector/error counts and a sticky error.
module gate_resp_checker #(
   parameter logic [3:0]  TRUTH  = 4'b1000,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vec_valid,
   input  logic             vec_a,
   input  logic             vec_b,
   output logic             vec_ready,
   output logic             dut_a,
   output logic             dut_b,
   input  logic             dut_f,
   output logic             chk_valid,
   output logic             chk_pass,
   output logic             exp_f,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sticky
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   localparam logic [3:0]       L_TIMER_LOAD = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] L_CNT_MAX    = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_timer;
   logic             w_accept;
   logic             w_sample;
   logic [1:0]       w_idx;
   logic             w_exp;
   logic             w_match;

   // Truth table is indexed by {a,b}: bit 3 is a=1,b=1, bit 0 is a=0,b=0.
   assign w_idx   = {dut_a, dut_b};
   assign w_exp   = TRUTH[w_idx];
   assign w_match = (dut_f == w_exp);

   // Next-state, handshake and strobe decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_sample    = 1'b0;
      vec_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            vec_ready = 1'b1;
            if (vec_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_timer == '0) begin
               w_sample    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register; reset overrides any in-flight vector.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Settle timer: loaded on acceptance, counts down to zero while waiting.
   always_ff @(posedge clk) begin
      if (rst)                                  r_timer <= '0;
      else if (w_accept)                        r_timer <= L_TIMER_LOAD;
      else if (r_state == S_WAIT && r_timer != '0) r_timer <= r_timer - 4'd1;
   end

   // Stimulus registers, result fields and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         dut_a      <= 1'b0;
         dut_b      <= 1'b0;
         chk_valid  <= 1'b0;
         chk_pass   <= 1'b0;
         exp_f      <= 1'b0;
         vec_cnt    <= '0;
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else begin
         chk_valid <= w_sample;
         if (w_accept) begin
            dut_a <= vec_a;
            dut_b <= vec_b;
         end
         if (w_sample) begin
            exp_f    <= w_exp;
            chk_pass <= w_match;
            if (vec_cnt != L_CNT_MAX) vec_cnt <= vec_cnt + 1'b1;
            if (!w_match) begin
               err_sticky <= 1'b1;
               if (err_cnt != L_CNT_MAX) err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Randomized bench for gate_resp_checker: three instances with different
// truth tables, settle intervals and counter widths, each checked every cycle
// against a transaction-level reference model.
module tb_gate_resp_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] vv, va, vb, flt;
   logic [2:0] rdy, da, db, df, cv, cp, ef, st;
   logic [7:0] vc0, ec0, vc2, ec2;
   logic [1:0] vc1, ec1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Gate under test, with an injectable fault that inverts its output.
   assign df[0] = (da[0] & db[0]) ^ flt[0];
   assign df[1] = (da[1] & ~db[1]) ^ flt[1];
   assign df[2] = ~(da[2] & db[2]) ^ flt[2];

   gate_resp_checker #(.TRUTH(4'b1000), .SETTLE(2), .CNT_W(8)) u_and (
      .clk(clk), .rst(rst), .vec_valid(vv[0]), .vec_a(va[0]), .vec_b(vb[0]),
      .vec_ready(rdy[0]), .dut_a(da[0]), .dut_b(db[0]), .dut_f(df[0]),
      .chk_valid(cv[0]), .chk_pass(cp[0]), .exp_f(ef[0]),
      .vec_cnt(vc0), .err_cnt(ec0), .err_sticky(st[0]));

   gate_resp_checker #(.TRUTH(4'b0100), .SETTLE(3), .CNT_W(2)) u_anb (
      .clk(clk), .rst(rst), .vec_valid(vv[1]), .vec_a(va[1]), .vec_b(vb[1]),
      .vec_ready(rdy[1]), .dut_a(da[1]), .dut_b(db[1]), .dut_f(df[1]),
      .chk_valid(cv[1]), .chk_pass(cp[1]), .exp_f(ef[1]),
      .vec_cnt(vc1), .err_cnt(ec1), .err_sticky(st[1]));

   gate_resp_checker #(.TRUTH(4'b0111), .SETTLE(1), .CNT_W(8)) u_nand (
      .clk(clk), .rst(rst), .vec_valid(vv[2]), .vec_a(va[2]), .vec_b(vb[2]),
      .vec_ready(rdy[2]), .dut_a(da[2]), .dut_b(db[2]), .dut_f(df[2]),
      .chk_valid(cv[2]), .chk_pass(cp[2]), .exp_f(ef[2]),
      .vec_cnt(vc2), .err_cnt(ec2), .err_sticky(st[2]));

   // Reference model state, one slot per instance.
   int unsigned SETL[3] = '{2, 3, 1};
   int          CMAX[3] = '{255, 3, 255};
   int          edge_n  = 0;
   bit          m_busy[3];
   int          m_due[3];
   logic        m_a[3], m_b[3], m_cv[3], m_pass[3], m_exp[3], m_st[3];
   int          m_vcnt[3], m_ecnt[3];
   logic [31:0] o_vc[3], o_ec[3];

   function automatic logic ref_gate(input int i, input logic a, input logic b);
      case (i)
         0:       return a & b;
         1:       return a & ~b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   initial begin
      rst = 1'b1;
      vv  = '0;
      va  = '0;
      vb  = '0;
      flt = '0;
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 0; m_due[i] = 0;
         m_a[i] = 0; m_b[i] = 0; m_cv[i] = 0; m_pass[i] = 0; m_exp[i] = 0; m_st[i] = 0;
         m_vcnt[i] = 0; m_ecnt[i] = 0;
      end

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         // Model: a vector accepted at edge k is judged at edge k+SETTLE.
         for (int i = 0; i < 3; i++) begin
            m_cv[i] = 1'b0;
            if (rst) begin
               m_busy[i] = 0;
               m_a[i] = 0; m_b[i] = 0; m_pass[i] = 0; m_exp[i] = 0; m_st[i] = 0;
               m_vcnt[i] = 0; m_ecnt[i] = 0;
            end else if (m_busy[i] && edge_n == m_due[i]) begin
               m_exp[i]  = ref_gate(i, m_a[i], m_b[i]);
               m_pass[i] = (m_exp[i] ^ flt[i]) == m_exp[i];
               m_cv[i]   = 1'b1;
               m_busy[i] = 0;
               if (m_vcnt[i] < CMAX[i]) m_vcnt[i]++;
               if (!m_pass[i]) begin
                  m_st[i] = 1'b1;
                  if (m_ecnt[i] < CMAX[i]) m_ecnt[i]++;
               end
            end else if (!m_busy[i] && vv[i]) begin
               m_a[i]    = va[i];
               m_b[i]    = vb[i];
               m_busy[i] = 1;
               m_due[i]  = edge_n + int'(SETL[i]);
            end
         end
         edge_n++;

         @(negedge clk);
         o_vc[0] = 32'(vc0); o_vc[1] = 32'(vc1); o_vc[2] = 32'(vc2);
         o_ec[0] = 32'(ec0); o_ec[1] = 32'(ec1); o_ec[2] = 32'(ec2);
         for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("u%0d_ready", i), 32'(rdy[i]), 32'(!m_busy[i]));
            check_eq($sformatf("u%0d_dut_a", i), 32'(da[i]), 32'(m_a[i]));
            check_eq($sformatf("u%0d_dut_b", i), 32'(db[i]), 32'(m_b[i]));
            check_eq($sformatf("u%0d_chk_valid", i), 32'(cv[i]), 32'(m_cv[i]));
            check_eq($sformatf("u%0d_chk_pass", i), 32'(cp[i]), 32'(m_pass[i]));
            check_eq($sformatf("u%0d_exp_f", i), 32'(ef[i]), 32'(m_exp[i]));
            check_eq($sformatf("u%0d_vec_cnt", i), o_vc[i], 32'(m_vcnt[i]));
            check_eq($sformatf("u%0d_err_cnt", i), o_ec[i], 32'(m_ecnt[i]));
            check_eq($sformatf("u%0d_err_sticky", i), 32'(st[i]), 32'(m_st[i]));
         end

         // Occasional resets in the middle section; clean runs before and after.
         rst = (cyc >= 300 && cyc < 2500) ? ($urandom_range(0, 39) == 0) : 1'b0;
         for (int i = 0; i < 3; i++) begin
            vv[i]  = ($urandom_range(0, 9) < 7);
            va[i]  = 1'($urandom_range(0, 1));
            vb[i]  = 1'($urandom_range(0, 1));
            flt[i] = ($urandom_range(0, 3) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
